led_driver_decoder: RTL and testbench

Receive-side decoder for the LED-driver serial interface (SCLK, LAT, SIN) that the synchronizer and the data path drive toward the TLC5957-style drivers. It oversamples the three lines in the `clk` domain, shifts in SIN bits, measures LAT pulse widths in SCLK rising edges, and decodes each latch command into a captured 48-bit word plus status. It sits on the HPS-readable side as a loopback checker for the generated or HPS-overridden stream, and it doubles as a synthesizable driver model in benches.

---
 rtl/led_driver_decoder_if.sv | 38 +++
 rtl/led_driver_decoder.sv | 197 +++++++++++++++++++
 tb/tb_led_driver_decoder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_driver_decoder_if.sv
// Serial LED-driver lines (SCLK/LAT/SIN) toward the decoder and the decoded
// command/word/frame status coming back from it.
interface led_driver_decoder_if #(
  parameter int unsigned WORD_WIDTH        = 48,
  parameter int unsigned NB_LEDS_PER_GROUP = 16
);
  localparam int unsigned BCW = $clog2(WORD_WIDTH) + 2;
  localparam int unsigned FWW = $clog2(NB_LEDS_PER_GROUP) + 2;

  logic                  sclk;
  logic                  lat;
  logic                  sin;

  logic                  cmd_valid;
  logic [2:0]            cmd;
  logic                  word_valid;
  logic [WORD_WIDTH-1:0] word_data;
  logic [BCW-1:0]        bit_count;
  logic                  len_err;
  logic                  fc_err;
  logic                  frame_done;
  logic [FWW-1:0]        frame_words;
  logic                  frame_err;

  // Stream source: drives the serial lines, observes the decode results.
  modport master (
    output sclk, lat, sin,
    input  cmd_valid, cmd, word_valid, word_data, bit_count,
           len_err, fc_err, frame_done, frame_words, frame_err
  );

  // Decoder: samples the serial lines, reports decoded commands.
  modport slave (
    input  sclk, lat, sin,
    output cmd_valid, cmd, word_valid, word_data, bit_count,
           len_err, fc_err, frame_done, frame_words, frame_err
  );
endinterface

// File: rtl/led_driver_decoder.sv
// Receive-side decoder for the LED-driver serial stream: oversamples SCLK/LAT/SIN,
// shifts SIN on SCLK rises and decodes LAT pulse widths into latch commands.
module led_driver_decoder #(
  parameter int unsigned WORD_WIDTH        = 48,
  parameter int unsigned NB_LEDS_PER_GROUP = 16,
  parameter int unsigned SYNC_STAGES       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_driver_decoder_if.slave   bus
);

  localparam int unsigned BCW = $clog2(WORD_WIDTH) + 2;
  localparam int unsigned FWW = $clog2(NB_LEDS_PER_GROUP) + 2;
  localparam int unsigned LLW = 5;

  typedef enum logic [2:0] {
    CMD_NONE    = 3'd0,
    CMD_WRTGS   = 3'd1,
    CMD_LATGS   = 3'd2,
    CMD_WRTFC   = 3'd3,
    CMD_FCWRTEN = 3'd4,
    CMD_UNKNOWN = 3'd7
  } cmd_e;

  // Input synchronizers and edge-detect delay flops
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] lat_sync_q;
  logic [SYNC_STAGES-1:0] sin_sync_q;
  logic                   sclk_dly_q;
  logic                   lat_dly_q;

  logic sclk_s;
  logic lat_s;
  logic sin_s;
  logic sclk_rise;
  logic lat_fall;

  // Working state
  logic [WORD_WIDTH-1:0] shift_q,     shift_d;
  logic [BCW-1:0]        bit_cnt_q,   bit_cnt_d;
  logic [LLW-1:0]        lat_len_q,   lat_len_d;
  logic [FWW-1:0]        frame_cnt_q, frame_cnt_d;
  logic                  fc_armed_q,  fc_armed_d;

  // Registered outputs
  logic                  cmd_valid_q,   cmd_valid_d;
  cmd_e                  cmd_q,         cmd_d;
  logic                  word_valid_q,  word_valid_d;
  logic [WORD_WIDTH-1:0] word_data_q,   word_data_d;
  logic [BCW-1:0]        bit_count_q,   bit_count_d;
  logic                  len_err_q,     len_err_d;
  logic                  fc_err_q,      fc_err_d;
  logic                  frame_done_q,  frame_done_d;
  logic [FWW-1:0]        frame_words_q, frame_words_d;
  logic                  frame_err_q,   frame_err_d;

  cmd_e                  dec_cmd;
  logic [FWW-1:0]        frame_cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      lat_sync_q  <= '0;
      sin_sync_q  <= '0;
      sclk_dly_q  <= 1'b0;
      lat_dly_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      lat_sync_q  <= {lat_sync_q[SYNC_STAGES-2:0],  bus.lat};
      sin_sync_q  <= {sin_sync_q[SYNC_STAGES-2:0],  bus.sin};
      sclk_dly_q  <= sclk_s;
      lat_dly_q   <= lat_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign lat_s     = lat_sync_q[SYNC_STAGES-1];
  assign sin_s     = sin_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign lat_fall  = ~lat_s & lat_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      lat_len_q     <= '0;
      frame_cnt_q   <= '0;
      fc_armed_q    <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_q         <= CMD_NONE;
      word_valid_q  <= 1'b0;
      word_data_q   <= '0;
      bit_count_q   <= '0;
      len_err_q     <= 1'b0;
      fc_err_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_words_q <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      lat_len_q     <= lat_len_d;
      frame_cnt_q   <= frame_cnt_d;
      fc_armed_q    <= fc_armed_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_q         <= cmd_d;
      word_valid_q  <= word_valid_d;
      word_data_q   <= word_data_d;
      bit_count_q   <= bit_count_d;
      len_err_q     <= len_err_d;
      fc_err_q      <= fc_err_d;
      frame_done_q  <= frame_done_d;
      frame_words_q <= frame_words_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // Shift/count on SCLK rise first, then decode a LAT fall from the updated counts,
  // so a rise coinciding with the fall is still included in the word.
  always_comb begin
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    lat_len_d     = lat_len_q;
    frame_cnt_d   = frame_cnt_q;
    fc_armed_d    = fc_armed_q;
    cmd_valid_d   = 1'b0;
    cmd_d         = cmd_q;
    word_valid_d  = 1'b0;
    word_data_d   = word_data_q;
    bit_count_d   = bit_count_q;
    len_err_d     = 1'b0;
    fc_err_d      = 1'b0;
    frame_done_d  = 1'b0;
    frame_words_d = frame_words_q;
    frame_err_d   = 1'b0;
    dec_cmd       = CMD_NONE;
    frame_cnt_inc = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + FWW'(1);

    if (sclk_rise) begin
      shift_d = {shift_q[WORD_WIDTH-2:0], sin_s};
      if (bit_cnt_q != '1) begin
        bit_cnt_d = bit_cnt_q + BCW'(1);
      end
      if (lat_s && (lat_len_q != '1)) begin
        lat_len_d = lat_len_q + LLW'(1);
      end
    end

    // A LAT pulse that saw no SCLK rise leaves everything untouched.
    if (lat_fall && (lat_len_d != '0)) begin
      case (lat_len_d)
        LLW'(1):  dec_cmd = CMD_WRTGS;
        LLW'(3):  dec_cmd = CMD_LATGS;
        LLW'(5):  dec_cmd = CMD_WRTFC;
        LLW'(15): dec_cmd = CMD_FCWRTEN;
        default:  dec_cmd = CMD_UNKNOWN;
      endcase

      cmd_valid_d = 1'b1;
      cmd_d       = dec_cmd;
      bit_count_d = bit_cnt_d;
      fc_armed_d  = (dec_cmd == CMD_FCWRTEN);
      fc_err_d    = (dec_cmd == CMD_WRTFC) && !fc_armed_q;

      if ((dec_cmd == CMD_WRTGS) || (dec_cmd == CMD_LATGS) || (dec_cmd == CMD_WRTFC)) begin
        word_valid_d = 1'b1;
        word_data_d  = shift_d;
        len_err_d    = (bit_cnt_d != BCW'(WORD_WIDTH));
      end

      if (dec_cmd == CMD_WRTGS) begin
        frame_cnt_d = frame_cnt_inc;
      end else if (dec_cmd == CMD_LATGS) begin
        frame_done_d  = 1'b1;
        frame_words_d = frame_cnt_inc;
        frame_err_d   = (frame_cnt_inc != FWW'(NB_LEDS_PER_GROUP));
        frame_cnt_d   = '0;
      end

      bit_cnt_d = '0;
      lat_len_d = '0;
    end
  end

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd         = cmd_q;
  assign bus.word_valid  = word_valid_q;
  assign bus.word_data   = word_data_q;
  assign bus.bit_count   = bit_count_q;
  assign bus.len_err     = len_err_q;
  assign bus.fc_err      = fc_err_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_words = frame_words_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_led_driver_decoder.sv
// Randomized bench for led_driver_decoder: drives the serial stream and checks
// each decoded command against a command-level reference model.
module tb_led_driver_decoder;

  localparam int unsigned WW = 48;
  localparam int unsigned NB = 16;

  logic clk;
  logic rst_n;

  led_driver_decoder_if #(.WORD_WIDTH(WW), .NB_LEDS_PER_GROUP(NB)) bus ();

  led_driver_decoder #(.WORD_WIDTH(WW), .NB_LEDS_PER_GROUP(NB), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;
  int n_pulses;
  int n_exp_pulses;

  // Reference model state (command-level view of the stream)
  logic [WW-1:0] m_sr;
  int            m_bits;
  int            m_lat;
  int            m_frame;
  bit            m_armed;
  logic [WW-1:0] m_word;
  int            m_fwords;

  // Observed flags of the most recent command pulse
  logic       obs_len_err, obs_fc_err, obs_frame_done, obs_frame_err, obs_word_valid;
  logic [2:0] obs_cmd;

  always @(negedge clk) if (bus.cmd_valid === 1'b1) n_pulses++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sr = '0; m_bits = 0; m_lat = 0; m_frame = 0; m_armed = 0; m_word = '0; m_fwords = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_valid"},   64'(bus.cmd_valid),   0);
    check({tag, "_cmd"},         64'(bus.cmd),         0);
    check({tag, "_word_valid"},  64'(bus.word_valid),  0);
    check({tag, "_word_data"},   64'(bus.word_data),   0);
    check({tag, "_bit_count"},   64'(bus.bit_count),   0);
    check({tag, "_len_err"},     64'(bus.len_err),     0);
    check({tag, "_fc_err"},      64'(bus.fc_err),      0);
    check({tag, "_frame_done"},  64'(bus.frame_done),  0);
    check({tag, "_frame_words"}, 64'(bus.frame_words), 0);
    check({tag, "_frame_err"},   64'(bus.frame_err),   0);
  endtask

  // Shift n bits MSB first; LAT is high over the last l rises; optionally drop LAT.
  task automatic send_bits(input logic [63:0] data, input int n, input int l, input bit drop);
    for (int i = n - 1; i >= 0; i--) begin
      bus.sin = data[i];
      bus.lat = (i < l);
      repeat (3) @(negedge clk);
      bus.sclk = 1'b1;
      m_sr   = {m_sr[WW-2:0], data[i]};
      m_bits = (m_bits < 255) ? m_bits + 1 : 255;
      if (bus.lat) m_lat = (m_lat < 31) ? m_lat + 1 : 31;
      repeat (3) @(negedge clk);
      bus.sclk = 1'b0;
    end
    if (drop) begin
      repeat (2) @(negedge clk);
      bus.lat = 1'b0;
    end
  endtask

  function automatic logic [2:0] cmd_of(input int l);
    case (l)
      1:       return 3'd1;
      3:       return 3'd2;
      5:       return 3'd3;
      15:      return 3'd4;
      default: return 3'd7;
    endcase
  endfunction

  // Wait for the decode of the LAT pulse just ended and compare against the model.
  task automatic finish_cmd();
    bit         seen;
    bit         is_word;
    logic [2:0] ec;
    int         e_bc;
    bit         e_len, e_fc, e_done, e_ferr;
    seen = 0;
    if (m_lat == 0) begin
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (bus.cmd_valid) seen = 1;
      end
      check("ignored_no_pulse", 64'(seen), 0);
      return;
    end
    ec      = cmd_of(m_lat);
    is_word = (ec == 3'd1) || (ec == 3'd2) || (ec == 3'd3);
    e_bc    = m_bits;
    e_len   = is_word && (m_bits != WW);
    if (is_word) m_word = m_sr;
    e_fc    = (ec == 3'd3) && !m_armed;
    m_armed = (ec == 3'd4);
    e_done  = 0;
    e_ferr  = 0;
    if (ec == 3'd1 || ec == 3'd2) m_frame = (m_frame < 63) ? m_frame + 1 : 63;
    if (ec == 3'd2) begin
      e_done   = 1;
      m_fwords = m_frame;
      e_ferr   = (m_frame != NB);
      m_frame  = 0;
    end
    m_bits = 0;
    m_lat  = 0;
    n_exp_pulses++;

    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (bus.cmd_valid) seen = 1;
    end
    check("cmd_valid_seen", 64'(seen), 1);
    if (seen) begin
      obs_cmd        = bus.cmd;
      obs_len_err    = bus.len_err;
      obs_fc_err     = bus.fc_err;
      obs_frame_done = bus.frame_done;
      obs_frame_err  = bus.frame_err;
      obs_word_valid = bus.word_valid;
      check("cmd",         64'(bus.cmd),         64'(ec));
      check("word_valid",  64'(bus.word_valid),  64'(is_word));
      check("word_data",   64'(bus.word_data),   64'(m_word));
      check("bit_count",   64'(bus.bit_count),   64'(e_bc));
      check("len_err",     64'(bus.len_err),     64'(e_len));
      check("fc_err",      64'(bus.fc_err),      64'(e_fc));
      check("frame_done",  64'(bus.frame_done),  64'(e_done));
      check("frame_words", 64'(bus.frame_words), 64'(m_fwords));
      check("frame_err",   64'(bus.frame_err),   64'(e_ferr));
      @(negedge clk);
      check("cmd_valid_one_cycle",  64'(bus.cmd_valid),  0);
      check("word_valid_one_cycle", 64'(bus.word_valid), 0);
    end
  endtask

  task automatic do_cmd(input logic [63:0] data, input int n, input int l);
    send_bits(data, n, l, 1'b1);
    finish_cmd();
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    int nb;
    int nl;
    int sel;
    n_chk = 0; n_err = 0; n_pulses = 0; n_exp_pulses = 0;
    bus.sclk = 1'b0; bus.lat = 1'b0; bus.sin = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Full frame: 15 WRTGS (first is the reference word) then LATGS
    do_cmd(64'h0000_A5A5_1234_5678, 48, 1);
    check("tp_cmd_wrtgs",  64'(obs_cmd),         1);
    check("tp_word",       64'(bus.word_data),   64'h0000_A5A5_1234_5678);
    check("tp_bit_count",  64'(bus.bit_count),   48);
    check("tp_len_err",    64'(obs_len_err),     0);
    for (int i = 0; i < 14; i++) do_cmd(rnd64(), 48, 1);
    do_cmd(rnd64(), 48, 3);
    check("tp_frame_done", 64'(obs_frame_done),  1);
    check("tp_frame_16",   64'(bus.frame_words), 16);
    check("tp_frame_err0", 64'(obs_frame_err),   0);

    // Short frame
    for (int i = 0; i < 3; i++) do_cmd(rnd64(), 48, 1);
    do_cmd(rnd64(), 48, 3);
    check("tp_frame_4",    64'(bus.frame_words), 4);
    check("tp_frame_err1", 64'(obs_frame_err),   1);

    // FC write enable then two WRTFC
    do_cmd(rnd64(), 15, 15);
    check("tp_fcwrten", 64'(obs_cmd), 4);
    do_cmd(rnd64(), 48, 5);
    check("tp_wrtfc",    64'(obs_cmd),    3);
    check("tp_fc_err0",  64'(obs_fc_err), 0);
    do_cmd(rnd64(), 48, 5);
    check("tp_fc_err1",  64'(obs_fc_err), 1);

    // Short word and an unknown LAT width
    do_cmd(rnd64(), 47, 1);
    check("tp_len_err1",   64'(obs_len_err),   1);
    check("tp_bc47",       64'(bus.bit_count), 47);
    do_cmd(rnd64(), 48, 7);
    check("tp_unknown",    64'(obs_cmd),        7);
    check("tp_unknown_wv", 64'(obs_word_valid), 0);

    // LAT pulse with no SCLK rise is ignored
    bus.lat = 1'b1;
    repeat (5) @(negedge clk);
    bus.lat = 1'b0;
    finish_cmd();

    // Randomized command mix
    for (int t = 0; t < 25; t++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       nb = 47;
        1:       nb = 49;
        2, 3:    nb = int'($urandom_range(8, 60));
        default: nb = 48;
      endcase
      sel = int'($urandom_range(0, 7));
      case (sel)
        0, 1:    nl = 1;
        2:       nl = 3;
        3:       nl = 5;
        4:       nl = 15;
        default: nl = int'($urandom_range(1, 20));
      endcase
      if (nl > nb) nl = nb;
      do_cmd(rnd64(), nb, nl);
      if ($urandom_range(0, 4) == 0) begin
        bus.lat = 1'b1;
        repeat (3) @(negedge clk);
        bus.lat = 1'b0;
        finish_cmd();
      end
    end

    // Reset in the middle of a word
    send_bits(rnd64(), 20, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    do_cmd(rnd64(), 48, 1);
    check("post_reset_cmd", 64'(obs_cmd),       1);
    check("post_reset_bc",  64'(bus.bit_count), 48);

    repeat (5) @(negedge clk);
    check("pulse_total", 64'(n_pulses), 64'(n_exp_pulses));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
